// File: rtl/ffe_coeff_bank_pkg.sv
// Shared definitions for the FFE coefficient bank: tap geometry, adaptation states,
// the reset coefficient pattern and the flat tap packing used by the LMS and FIR stages.
package ffe_coeff_bank_pkg;

    localparam int FFE_LEN    = 21;
    localparam int NB         = 8;
    localparam int NBF        = 7;
    localparam int NB_CNT     = 16;
    localparam int CENTER_TAP = 10;
    localparam int NB_ADDR    = 5;
    localparam int NB_FLAT    = FFE_LEN * NB;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_ADAPT  = 2'd2,
        ST_FROZEN = 2'd3
    } adapt_state_e;

    // Unity in Q(NB-NBF).NBF does not fit when NBF = NB-1, so it saturates to the largest positive value.
    localparam logic [NB-1:0] UNITY = (NBF >= NB - 1) ? {1'b0, {(NB-1){1'b1}}} : NB'(1 << NBF);

    // Tap k occupies flat bits [k*NB +: NB].
    function automatic int tap_lsb(input int k);
        return k * NB;
    endfunction

    function automatic logic [NB_FLAT-1:0] reset_pattern();
        logic [NB_FLAT-1:0] flat;
        flat = '0;
        flat[tap_lsb(CENTER_TAP) +: NB] = UNITY;
        return flat;
    endfunction

endpackage

// File: rtl/ffe_adapt_ctrl.sv
// Adaptation sequencer: INIT/WARMUP/ADAPT/FROZEN state machine with warm-up and
// decimation counters; raises commit in the cycle a commit valid is accepted.
module ffe_adapt_ctrl
    import ffe_coeff_bank_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic              enable,
    input  logic [NB_CNT-1:0] warmup_len,
    input  logic [7:0]        update_period,
    output logic              commit,
    output adapt_state_e      state
);

    // valid is a pure qualifier shared with the LMS stage: a sample counts in the cycle
    // valid is high at the rising edge; there is no ready and no backpressure.
    adapt_state_e      state_q, state_d;
    logic [NB_CNT-1:0] warm_cnt_q, warm_cnt_d;
    logic [NB_CNT-1:0] period_cnt_q, period_cnt_d;
    logic [NB_CNT-1:0] warm_last;
    logic [NB_CNT-1:0] period_last;
    logic              period_hit;

    assign warm_last   = warmup_len - NB_CNT'(1);
    assign period_last = (update_period == 8'd0) ? '0 : NB_CNT'(update_period - 8'd1);
    assign period_hit  = (period_cnt_q == period_last);
    assign state       = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            warm_cnt_q   <= '0;
            period_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            period_cnt_q <= period_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        period_cnt_d = period_cnt_q;
        commit       = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (warmup_len != '0) state_d = ST_WARMUP;
                else                  state_d = enable ? ST_ADAPT : ST_FROZEN;
            end
            ST_WARMUP: begin
                if (valid) begin
                    warm_cnt_d = warm_cnt_q + NB_CNT'(1);
                    if (warm_cnt_q == warm_last) state_d = enable ? ST_ADAPT : ST_FROZEN;
                end
            end
            ST_ADAPT: begin
                // Dropping enable wins over a commit due in the same cycle.
                if (!enable) begin
                    state_d = ST_FROZEN;
                end else if (valid) begin
                    if (period_hit) begin
                        period_cnt_d = '0;
                        commit       = 1'b1;
                    end else begin
                        period_cnt_d = period_cnt_q + NB_CNT'(1);
                    end
                end
            end
            ST_FROZEN: begin
                if (enable) state_d = ST_ADAPT;
            end
            default: state_d = ST_INIT;
        endcase
        if (state_d == ST_ADAPT && state_q != ST_ADAPT) period_cnt_d = '0;
    end

endmodule

// File: rtl/ffe_coeff_bank.sv
// Live FFE coefficient register bank: commits LMS proposals when the adaptation
// sequencer allows it and accepts single-tap host writes, which take priority.
module ffe_coeff_bank
    import ffe_coeff_bank_pkg::*;
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic                      i_enable,
    input  logic [FFE_LEN*NB-1:0]     i_new_coeff,
    input  logic [NB_CNT-1:0]         i_warmup_len,
    input  logic [7:0]                i_update_period,
    input  logic                      i_load,
    input  logic [NB_ADDR-1:0]        i_load_addr,
    input  logic [NB-1:0]             i_load_data,
    output logic [FFE_LEN*NB-1:0]     o_coeff_flat,
    output logic                      o_update,
    output logic [1:0]                o_state,
    output logic [NB_CNT-1:0]         o_update_count
);

    adapt_state_e      state;
    logic              commit;
    logic              load_hit;
    logic [NB_FLAT-1:0] coeff_q;
    logic              update_q;
    logic [NB_CNT-1:0] count_q;

    ffe_adapt_ctrl u_ctrl (
        .clock         (i_clock),
        .reset         (i_reset),
        .valid         (i_valid),
        .enable        (i_enable),
        .warmup_len    (i_warmup_len),
        .update_period (i_update_period),
        .commit        (commit),
        .state         (state)
    );

    // Out-of-range addresses behave as if no load were requested.
    assign load_hit = i_load && (state != ST_INIT) && (i_load_addr < NB_ADDR'(FFE_LEN));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            coeff_q  <= reset_pattern();
            update_q <= 1'b0;
            count_q  <= '0;
        end else if (load_hit) begin
            coeff_q[tap_lsb(int'(i_load_addr)) +: NB] <= i_load_data;
            update_q <= 1'b0;
        end else if (commit) begin
            coeff_q  <= i_new_coeff;
            update_q <= 1'b1;
            if (count_q != '1) count_q <= count_q + NB_CNT'(1);
        end else begin
            update_q <= 1'b0;
        end
    end

    assign o_coeff_flat   = coeff_q;
    assign o_update       = update_q;
    assign o_state        = state;
    assign o_update_count = count_q;

endmodule

// File: tb/tb_ffe_coeff_bank.sv
// Self-checking bench for ffe_coeff_bank: table-driven decimation vectors plus
// hand-written sequences for warm-up, freeze, host load and mid-run reset.
module tb_ffe_coeff_bank;

    localparam int TAPS  = 21;
    localparam int TB_NB = 8;
    localparam int FLAT  = TAPS * TB_NB;
    localparam int CNTW  = 16;
    localparam int W     = 1 + CNTW + 2 + FLAT;

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_ADAPT  = 2'd2;
    localparam logic [1:0] S_FROZEN = 2'd3;

    logic            clk;
    logic            rst;
    logic            valid;
    logic            enable;
    logic [FLAT-1:0] new_coeff;
    logic [CNTW-1:0] warmup_len;
    logic [7:0]      update_period;
    logic            load;
    logic [4:0]      load_addr;
    logic [7:0]      load_data;
    logic [FLAT-1:0] coeff_flat;
    logic            update;
    logic [1:0]      state;
    logic [CNTW-1:0] update_count;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    typedef struct {
        logic            valid;
        logic [FLAT-1:0] new_flat;
        logic            exp_upd;
        logic [CNTW-1:0] exp_cnt;
        logic [FLAT-1:0] exp_flat;
    } vec_t;

    vec_t tbl[11];

    ffe_coeff_bank dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_valid         (valid),
        .i_enable        (enable),
        .i_new_coeff     (new_coeff),
        .i_warmup_len    (warmup_len),
        .i_update_period (update_period),
        .i_load          (load),
        .i_load_addr     (load_addr),
        .i_load_data     (load_data),
        .o_coeff_flat    (coeff_flat),
        .o_update        (update),
        .o_state         (state),
        .o_update_count  (update_count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [FLAT-1:0] fill(input logic [7:0] v);
        logic [FLAT-1:0] r;
        for (int k = 0; k < TAPS; k++) r[k*TB_NB +: TB_NB] = v;
        return r;
    endfunction

    function automatic logic [FLAT-1:0] ramp(input logic [7:0] base);
        logic [FLAT-1:0] r;
        for (int k = 0; k < TAPS; k++) r[k*TB_NB +: TB_NB] = base + 8'(k);
        return r;
    endfunction

    function automatic logic [FLAT-1:0] rst_pat();
        logic [FLAT-1:0] r;
        r = '0;
        r[10*TB_NB +: TB_NB] = 8'h7F;
        return r;
    endfunction

    task automatic check(input string name, input logic [FLAT-1:0] act, input logic [FLAT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver + scoreboard: expectation queued with the stimulus, popped after the edge.
    task automatic step(input string tag, input logic e_upd, input logic [CNTW-1:0] e_cnt,
                        input logic [1:0] e_st, input logic [FLAT-1:0] e_flat);
        logic [W-1:0] e;
        exp_q.push_back({e_upd, e_cnt, e_st, e_flat});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".coeff"},  coeff_flat,           e[FLAT-1:0]);
            check({tag, ".update"}, FLAT'(update),        FLAT'(e[W-1]));
            check({tag, ".count"},  FLAT'(update_count),  FLAT'(e[W-2 -: CNTW]));
            check({tag, ".state"},  FLAT'(state),         FLAT'(e[FLAT+1 : FLAT]));
        end
    endtask

    task automatic set_vec(input int i, input logic v, input logic [FLAT-1:0] nf,
                           input logic u, input logic [CNTW-1:0] c, input logic [FLAT-1:0] ef);
        tbl[i].valid    = v;
        tbl[i].new_flat = nf;
        tbl[i].exp_upd  = u;
        tbl[i].exp_cnt  = c;
        tbl[i].exp_flat = ef;
    endtask

    initial begin
        logic [FLAT-1:0] t5;
        n_checks = 0;
        n_fail   = 0;

        // Period-3 decimation vectors; commits land on every third valid, gaps do not count.
        set_vec(0,  1'b1, ramp(8'h11), 1'b0, 16'd1, fill(8'h05));
        set_vec(1,  1'b1, ramp(8'h12), 1'b0, 16'd1, fill(8'h05));
        set_vec(2,  1'b1, ramp(8'h13), 1'b1, 16'd2, ramp(8'h13));
        set_vec(3,  1'b0, ramp(8'h14), 1'b0, 16'd2, ramp(8'h13));
        set_vec(4,  1'b1, ramp(8'h15), 1'b0, 16'd2, ramp(8'h13));
        set_vec(5,  1'b1, ramp(8'h16), 1'b0, 16'd2, ramp(8'h13));
        set_vec(6,  1'b1, ramp(8'h17), 1'b1, 16'd3, ramp(8'h17));
        set_vec(7,  1'b1, ramp(8'h18), 1'b0, 16'd3, ramp(8'h17));
        set_vec(8,  1'b0, ramp(8'h19), 1'b0, 16'd3, ramp(8'h17));
        set_vec(9,  1'b1, ramp(8'h1A), 1'b0, 16'd3, ramp(8'h17));
        set_vec(10, 1'b1, ramp(8'h1B), 1'b1, 16'd4, ramp(8'h1B));

        rst = 1'b1; valid = 1'b0; enable = 1'b1; new_coeff = '0;
        warmup_len = 16'd4; update_period = 8'd1;
        load = 1'b0; load_addr = '0; load_data = '0;

        // Reset pattern, then INIT lasts one cycle before warm-up
        step("t1_reset", 1'b0, 16'd0, S_INIT, rst_pat());
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step("t1_idle", 1'b0, 16'd0, S_WARMUP, rst_pat());

        // Warm-up skips 4 valids; the 5th commits one cycle later
        new_coeff = fill(8'h05);
        valid = 1'b1;
        for (int i = 0; i < 3; i++) step("t2_warm", 1'b0, 16'd0, S_WARMUP, rst_pat());
        step("t2_warm_last", 1'b0, 16'd0, S_ADAPT, rst_pat());
        step("t2_commit", 1'b1, 16'd1, S_ADAPT, fill(8'h05));
        valid = 1'b0;
        step("t2_after", 1'b0, 16'd1, S_ADAPT, fill(8'h05));

        update_period = 8'd3;
        for (int i = 0; i < 11; i++) begin
            valid     = tbl[i].valid;
            new_coeff = tbl[i].new_flat;
            step($sformatf("t3_vec%0d", i), tbl[i].exp_upd, tbl[i].exp_cnt, S_ADAPT, tbl[i].exp_flat);
        end

        // Freeze on the commit valid, then resume with a cleared period counter
        new_coeff = ramp(8'h30);
        valid = 1'b1;
        step("t4_v1", 1'b0, 16'd4, S_ADAPT, ramp(8'h1B));
        step("t4_v2", 1'b0, 16'd4, S_ADAPT, ramp(8'h1B));
        enable = 1'b0;
        step("t4_freeze", 1'b0, 16'd4, S_FROZEN, ramp(8'h1B));
        new_coeff = ramp(8'h40);
        for (int i = 0; i < 10; i++) step("t4_frozen", 1'b0, 16'd4, S_FROZEN, ramp(8'h1B));
        valid = 1'b0;
        enable = 1'b1;
        step("t4_resume", 1'b0, 16'd4, S_ADAPT, ramp(8'h1B));
        valid = 1'b1;
        step("t4_p1", 1'b0, 16'd4, S_ADAPT, ramp(8'h1B));
        step("t4_p2", 1'b0, 16'd4, S_ADAPT, ramp(8'h1B));
        step("t4_p3", 1'b1, 16'd5, S_ADAPT, ramp(8'h40));

        // Host load against a commit valid, out-of-range and boundary addresses
        new_coeff = ramp(8'h50);
        step("t5_p1", 1'b0, 16'd5, S_ADAPT, ramp(8'h40));
        step("t5_p2", 1'b0, 16'd5, S_ADAPT, ramp(8'h40));
        t5 = ramp(8'h40);
        t5[7*TB_NB +: TB_NB] = 8'h80;
        load = 1'b1; load_addr = 5'd7; load_data = 8'h80;
        step("t5_load_vs_commit", 1'b0, 16'd5, S_ADAPT, t5);
        valid = 1'b0;
        load_addr = 5'd25; load_data = 8'h33;
        step("t5_addr25", 1'b0, 16'd5, S_ADAPT, t5);
        load_addr = 5'd21;
        step("t5_addr21", 1'b0, 16'd5, S_ADAPT, t5);
        load_addr = 5'd0; load_data = 8'hAA;
        t5[0 +: TB_NB] = 8'hAA;
        step("t5_addr0", 1'b0, 16'd5, S_ADAPT, t5);
        load_addr = 5'd20; load_data = 8'h9C;
        t5[20*TB_NB +: TB_NB] = 8'h9C;
        step("t5_addr20", 1'b0, 16'd5, S_ADAPT, t5);
        load = 1'b0;
        valid = 1'b1;
        step("t5_wrap1", 1'b0, 16'd5, S_ADAPT, t5);
        step("t5_wrap2", 1'b0, 16'd5, S_ADAPT, t5);
        step("t5_wrap3", 1'b1, 16'd6, S_ADAPT, ramp(8'h50));

        // Period 0 commits on every valid; bring the count to 12
        update_period = 8'd0;
        for (int i = 0; i < 6; i++) begin
            new_coeff = ramp(8'h60 + 8'(i));
            step("t6_p0", 1'b1, 16'(7 + i), S_ADAPT, ramp(8'h60 + 8'(i)));
        end

        // Mid-ADAPT reset with valid and load present; load in INIT is ignored
        rst = 1'b1;
        load = 1'b1; load_addr = 5'd3; load_data = 8'h11;
        new_coeff = ramp(8'h77);
        step("t6_reset", 1'b0, 16'd0, S_INIT, rst_pat());
        rst = 1'b0;
        warmup_len = 16'd0;
        update_period = 8'd1;
        step("t6_init_load", 1'b0, 16'd0, S_ADAPT, rst_pat());
        load = 1'b0;
        new_coeff = ramp(8'h70);
        step("t6_nowarm_commit", 1'b1, 16'd1, S_ADAPT, ramp(8'h70));

        // Zero warm-up with enable low goes straight to FROZEN; loads still apply there
        rst = 1'b1;
        step("t7_reset", 1'b0, 16'd0, S_INIT, rst_pat());
        rst = 1'b0;
        enable = 1'b0;
        step("t7_init", 1'b0, 16'd0, S_FROZEN, rst_pat());
        step("t7_frozen", 1'b0, 16'd0, S_FROZEN, rst_pat());
        t5 = rst_pat();
        t5[10*TB_NB +: TB_NB] = 8'h01;
        load = 1'b1; load_addr = 5'd10; load_data = 8'h01;
        step("t7_frozen_load", 1'b0, 16'd0, S_FROZEN, t5);
        load = 1'b0;
        valid = 1'b0;
        step("t7_hold", 1'b0, 16'd0, S_FROZEN, t5);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ffe_coeff_bank.md
Name: ffe_coeff_bank

Overview:
- Coefficient register bank placed downstream of the LMS tap-update stage.
- Holds the FFE_LEN live FFE coefficients. Its output feeds the FIR datapath and also returns to the LMS stage as its current-coefficient input.
- Decides when the LMS update proposal is committed: reset init, warm-up skip, decimated update period, freeze control, and host tap load.

Parameters:
FFE_LEN, 21, number of taps
NB, 8, coefficient width (signed)
NBF, 7, coefficient fractional bits
NB_CNT, 16, width of warm-up and update counters
CENTER_TAP, 10, tap index initialised to unity at reset
NB_ADDR, 5, host load address width (ceil log2 FFE_LEN)

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  sample strobe, same strobe as the LMS stage
i_enable  in  1  adaptation enable; low freezes coefficients
i_new_coeff  in  FFE_LEN*NB  LMS-proposed coefficients; tap k at [k*NB +: NB]
i_warmup_len  in  NB_CNT  valid samples skipped before the first commit
i_update_period  in  8  commit on every Nth valid in ADAPT; 0 is treated as 1
i_load  in  1  host single-tap write strobe
i_load_addr  in  NB_ADDR  host tap index
i_load_data  in  NB  host tap value
o_coeff_flat  out  FFE_LEN*NB  registered live coefficients, same packing as i_new_coeff
o_update  out  1  one-cycle pulse, high in the cycle o_coeff_flat shows a committed update
o_state  out  2  INIT=0, WARMUP=1, ADAPT=2, FROZEN=3
o_update_count  out  NB_CNT  number of commits since reset, saturating

Behaviour:
Reset (synchronous, i_reset high at a rising edge):
- All taps = 0, except tap CENTER_TAP = 2^(NB-1)-1 (0x7F, saturated unity).
- o_update = 0, o_update_count = 0, state = INIT, warm-up and period counters = 0.
- Reset asserted mid-operation has the same effect. No partial commit may survive it.

State machine:
- INIT: exactly one cycle after reset, no commits.
  - Next state is WARMUP if i_warmup_len != 0.
  - Otherwise next state is ADAPT if i_enable = 1, else FROZEN.
- WARMUP: warm-up counter increments on each i_valid, independent of i_enable.
  - When a valid arrives with count == i_warmup_len-1, next state is ADAPT if i_enable = 1, else FROZEN.
- ADAPT:
  - If i_enable = 0, next state is FROZEN. Any commit due in that same cycle is suppressed.
  - Period counter increments on i_valid. A valid with counter == max(i_update_period,1)-1 is a commit valid: counter returns to 0 and all taps load i_new_coeff.
- FROZEN: taps hold their value. When i_enable returns to 1, next state is ADAPT.
- Entering ADAPT from any state clears the period counter.

Commit timing:
- Commit latency is 1 cycle: taps and o_update change at the edge after the commit valid.
- o_update_count increments on each commit and saturates at 2^NB_CNT-1.

Host load:
- Active in every state except INIT and reset.
- i_load writes i_load_data into tap i_load_addr at the next edge.
- i_load_addr >= FFE_LEN is ignored entirely.
- Load coinciding with a commit: the load wins, the whole commit is dropped, o_update stays 0, and the period counter still wraps to 0.
- A load never pulses o_update and never changes o_update_count.

Other rules:
- i_update_period or i_warmup_len changing mid-count takes effect on the next comparison. No counter reset.
- No arithmetic on coefficients; values pass through bit-exact. Saturation is the upstream stage's job.

Decomposition:
- Shared package holds:
  - state encodings INIT/WARMUP/ADAPT/FROZEN (2 bits);
  - the reset-pattern function (zero vector with the centre tap set to 2^(NB-1)-1);
  - the flat pack/unpack index convention shared with the LMS and FIR stages.
- One natural sub-module: ffe_adapt_ctrl, containing the FSM plus warm-up and period counters. It outputs a commit-strobe and the state.
- The tap register array and load/commit mux stay in the top block.

Test Plan:
1. Reset, then hold i_valid = 0 for 5 cycles -> tap 10 = 0x7F, all other taps = 0, o_state goes INIT -> WARMUP (i_warmup_len = 4), o_update never asserted.
2. i_warmup_len = 4, i_update_period = 1, i_enable = 1, i_new_coeff all taps 0x05, continuous valid -> first 4 valids produce no change; 5th valid causes all taps = 0x05 and o_update = 1 one cycle later; count = 1.
3. ADAPT with i_update_period = 3, 9 consecutive valids, i_new_coeff changing each sample -> exactly 3 o_update pulses; each commit captures the value present on valids 3, 6 and 9; o_update_count = 3.
4. In ADAPT, drop i_enable during a commit valid -> no commit, o_state = FROZEN. After 10 valids raise i_enable -> state ADAPT; the period counter restarts at 0.
5. i_load = 1, addr 7, data 0x80 in the same cycle as a commit valid -> tap 7 = 0x80, other taps unchanged, o_update = 0. A load with addr 25 changes nothing.
6. Assert i_reset for one cycle mid-ADAPT with count = 12 -> next cycle shows the reset pattern, count = 0, state = INIT.
